fifo_drain_ctrl: RTL and testbench

- Read-side stage directly downstream of synchronous_fifo.
- Drives the FIFO's r_en and absorbs its one-cycle read latency.
- Presents the drained words as a valid/ready stream (m_valid/m_ready/m_data) through a 2-entry output buffer.
- Sustains one word per cycle with no bubbles and never reads an empty FIFO.

---
 rtl/fifo_drain_ctrl.sv | 96 +++++++++
 tb/tb_fifo_drain_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain stage for synchronous_fifo: issues r_en, absorbs the one-cycle read
// latency and re-times words into a 2-entry valid/ready output buffer.
// Optional macro FIFO_DRAIN_STATS_EN adds beat_cnt/stall_cnt counters.
module fifo_drain_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data_out,
  output logic             fifo_r_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  input  logic             flush,
  output logic             busy
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [15:0]      beat_cnt,
  output logic [15:0]      stall_cnt
`endif
);

  logic [WIDTH-1:0] buf_q [2];
  logic [1:0]       count;
  logic             rd_ptr;
  logic             wr_ptr;
  logic             inflight;

  logic             pop;
  logic             push;
  logic [2:0]       occupancy;

  assign m_valid = (count != 2'd0) && !flush;
  assign m_data  = buf_q[rd_ptr];
  assign pop     = m_valid && m_ready;
  assign push    = inflight && !flush;
  assign busy    = (count != 2'd0) || inflight;

  // Slots already committed after this cycle's pop; a new read may only claim a free one.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  // Gated by rst_n so no read is issued while the state is being held in reset.
  assign fifo_r_en = rst_n && !flush && !fifo_empty && (occupancy < 3'd2);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      inflight <= 1'b0;
      // NOTE: the buffer is only two registers and drives m_data directly, so it is
      // reset to give a defined m_data of zero out of reset.
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (flush) begin
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_r_en;
      if (push) begin
        buf_q[wr_ptr] <= fifo_data_out;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef FIFO_DRAIN_STATS_EN
  // Free-running 16-bit counters; natural overflow gives the 0xFFFF -> 0 wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= 16'd0;
      stall_cnt <= 16'd0;
    end else if (flush) begin
      beat_cnt  <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (pop) begin
        beat_cnt <= beat_cnt + 16'd1;
      end
      if (m_valid && !m_ready) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl: queue-based FIFO environment plus a
// word-level reference model of what must appear on the output stream.
module tb_fifo_drain_ctrl;
  localparam int WIDTH      = 8;
  localparam int FIFO_DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data_out;
  logic             fifo_r_en;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             flush;
  logic             busy;
`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0]      beat_cnt;
  logic [15:0]      stall_cnt;
  logic [15:0]      beat_m;
  logic [15:0]      stall_m;
`endif

  int errors = 0;
  int checks = 0;

  // FIFO environment
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] fifo_q [$];

  // Reference model: words read from the FIFO that must still be delivered, oldest first.
  logic [WIDTH-1:0] exp_q [$];
  bit               exp_inflight;

  // Observation records
  int               cycle = 0;
  int               reads = 0;
  int               max_out = 0;
  int               empty_fall = -1;
  logic [WIDTH-1:0] pop_data [$];
  int               pop_cycle [$];

  fifo_drain_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_data_out(fifo_data_out),
    .fifo_r_en    (fifo_r_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .flush        (flush),
    .busy         (busy)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .beat_cnt     (beat_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: settle, compare against the model, take the edge, update
  // model and FIFO environment, return at the following negedge.
  task automatic tick();
    int  buffered;
    bit  exp_valid;
    bit  exp_pop;
    bit  exp_ren;
    bit  took_read;
    bit  was_empty;
    #1;
    if (!rst_n) begin
      exp_q.delete();
      exp_inflight = 0;
`ifdef FIFO_DRAIN_STATS_EN
      beat_m  = 16'd0;
      stall_m = 16'd0;
`endif
    end
    buffered  = exp_q.size() - (exp_inflight ? 1 : 0);
    exp_valid = rst_n && !flush && (buffered > 0);
    exp_pop   = exp_valid && m_ready;
    exp_ren   = rst_n && !flush && (fifo_q.size() != 0) &&
                ((buffered + (exp_inflight ? 1 : 0) - (exp_pop ? 1 : 0)) < 2);
    check("m_valid", m_valid, exp_valid);
    check("fifo_r_en", fifo_r_en, exp_ren);
    check("busy", busy, rst_n && (exp_q.size() != 0));
    check("read_while_empty", fifo_r_en && fifo_empty, 1'b0);
    if (exp_valid) check("m_data", m_data, exp_q[0]);
`ifdef FIFO_DRAIN_STATS_EN
    check("beat_cnt", beat_cnt, beat_m);
    check("stall_cnt", stall_cnt, stall_m);
`endif
    if (rst_n && m_valid && m_ready) begin
      pop_data.push_back(m_data);
      pop_cycle.push_back(cycle);
    end
    took_read = fifo_r_en && !fifo_empty;
    @(posedge clk);
    #1;
    cycle++;
    if (!rst_n || flush) begin
      exp_q.delete();
      exp_inflight = 0;
`ifdef FIFO_DRAIN_STATS_EN
      beat_m  = 16'd0;
      stall_m = 16'd0;
`endif
    end else begin
      if (exp_pop) void'(exp_q.pop_front());
`ifdef FIFO_DRAIN_STATS_EN
      if (exp_pop) beat_m = beat_m + 16'd1;
      if (exp_valid && !m_ready) stall_m = stall_m + 16'd1;
`endif
      exp_inflight = 0;
      if (took_read) begin
        exp_q.push_back(fifo_q[0]);
        exp_inflight = 1;
      end
    end
    if (exp_q.size() > max_out) max_out = exp_q.size();
    was_empty = fifo_empty;
    if (took_read) begin
      fifo_data_out = fifo_q.pop_front();
      reads++;
    end
    if (wr_en && fifo_q.size() < FIFO_DEPTH) fifo_q.push_back(wr_data);
    fifo_empty = (fifo_q.size() == 0);
    if (was_empty && !fifo_empty && empty_fall < 0) empty_fall = cycle;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL drain_timeout: ran %0d cycles, required fewer than %0d", n, budget);
    end
  endtask

  task automatic clear_records();
    pop_data.delete();
    pop_cycle.delete();
    empty_fall = -1;
  endtask

  initial begin
    logic [WIDTH-1:0] snap [$];
    logic [WIDTH-1:0] next_word;
    int               r0;
    int               n;

    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0; wr_en = 1'b0; wr_data = '0;
    fifo_empty = 1'b1; fifo_data_out = '0; exp_inflight = 0;
`ifdef FIFO_DRAIN_STATS_EN
    beat_m = 16'd0; stall_m = 16'd0;
`endif
    @(negedge clk);
    tick();
    check("reset_m_data", m_data, 8'h00);
    check("reset_m_valid", m_valid, 1'b0);
    rst_n = 1'b1;
    tick();

    // Streaming: 0x01..0x08 with m_ready=1
    clear_records();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = WIDTH'(i);
      tick();
    end
    wr_en = 1'b0;
    drain(40);
    check("stream_beats", pop_data.size(), 8);
    for (int i = 0; i < pop_data.size() && i < 8; i++) check("stream_data", pop_data[i], i + 1);
    if (pop_cycle.size() == 8) begin
      check("stream_first_latency", pop_cycle[0] - empty_fall, 2);
      check("stream_consecutive", pop_cycle[7] - pop_cycle[0], 7);
    end

    // Backpressure: 4 words, m_ready=0 for 10 cycles
    clear_records();
    m_ready = 1'b0;
    r0 = reads;
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_data = WIDTH'(i);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("bp_reads", reads - r0, 2);
    check("bp_m_data_held", m_data, 8'h01);
    check("bp_valid", m_valid, 1'b1);
    m_ready = 1'b1;
    drain(40);
    check("bp_beats", pop_data.size(), 4);
    for (int i = 0; i < pop_data.size() && i < 4; i++) check("bp_data", pop_data[i], i + 1);

    // Alternating ready with 8 words
    clear_records();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = WIDTH'(8'h21 + i); m_ready = i[0];
      tick();
    end
    wr_en = 1'b0;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 60) begin
      m_ready = ~m_ready;
      tick();
      n++;
    end
    check("alt_done", n < 60, 1'b1);
    check("alt_beats", pop_data.size(), 8);
    for (int i = 0; i < pop_data.size() && i < 8; i++) check("alt_data", pop_data[i], 8'h21 + i);

    // Flush while a read is in flight
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = WIDTH'(8'h31 + i);
      tick();
    end
    wr_en = 1'b0;
    check("flush_pre_inflight", exp_inflight && exp_q.size() == 2, 1'b1);
    next_word = fifo_q.size() != 0 ? fifo_q[0] : 8'h00;
    clear_records();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_m_valid", m_valid, 1'b0);
    check("flush_busy", busy, 1'b0);
    drain(40);
    check("flush_next_beat", pop_data.size() != 0 ? pop_data[0] : 8'hxx, next_word);
    check("flush_beats", pop_data.size(), 1);

    // Flush while the buffer is full
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = WIDTH'(8'h41 + i);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    clear_records();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    m_ready = 1'b1;
    drain(40);
    check("flush_full_beats", pop_data.size(), 1);
    check("flush_full_next", pop_data.size() != 0 ? pop_data[0] : 8'hxx, 8'h43);

    // Reset mid-stream with 3 words left in the FIFO
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = WIDTH'(8'h51 + i);
      tick();
    end
    wr_en = 1'b0;
    m_ready = 1'b1;
    tick();
    check("rst_pre_busy", busy, 1'b1);
    check("rst_fifo_words", fifo_q.size(), 3);
    snap = fifo_q;
    clear_records();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_fifo_r_en", fifo_r_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    drain(40);
    check("rst_beats", pop_data.size(), snap.size());
    for (int i = 0; i < pop_data.size() && i < snap.size(); i++) check("rst_data", pop_data[i], snap[i]);

`ifdef FIFO_DRAIN_STATS_EN
    // Stats: 5 accepted beats and 3 stalled cycles
    flush = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = WIDTH'(8'h61 + i);
      tick();
    end
    wr_en = 1'b0;
    flush = 1'b0;
    n = 0;
    while (!(exp_q.size() - (exp_inflight ? 1 : 0) > 0) && n < 10) begin
      tick();
      n++;
    end
    for (int i = 0; i < 3; i++) tick();
    m_ready = 1'b1;
    drain(40);
    check("stats_beat_cnt", beat_cnt, 16'd5);
    check("stats_stall_cnt", stall_cnt, 16'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("stats_beat_flush", beat_cnt, 16'd0);
    check("stats_stall_flush", stall_cnt, 16'd0);
`endif

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      wr_en   = ($urandom_range(0, 1) == 1) && (fifo_q.size() < FIFO_DEPTH);
      wr_data = WIDTH'($urandom);
      flush   = ($urandom_range(0, 31) == 0);
      tick();
    end
    wr_en = 1'b0; flush = 1'b0; m_ready = 1'b1;
    drain(60);

    check("max_outstanding_le_2", max_out <= 2, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
